// File: rtl/lvds_tx_framer_if.sv
// Nibble-stream handshake and line-side signals of the LVDS transmit framer.
// The master drives nibbles and the flag clear; the slave is the framer.
interface lvds_tx_framer_if;
    logic [3:0] d;
    logic       dv;
    logic       dr;
    logic       uf_clr;
    logic [1:0] o;
    logic       busy;
    logic       underflow;

    modport master (output d, dv, uf_clr, input dr, o, busy, underflow);
    modport slave  (input d, dv, uf_clr, output dr, o, busy, underflow);
endinterface

// File: rtl/lvds_tx_framer.sv
// Transmit framer: buffers nibbles in a small FIFO and serialises them, 2 bits/clock,
// as idle-high line, one start bit, NNIB nibbles MSB-first, then GAP idle clocks.
module lvds_tx_framer #(
    parameter int NNIB  = 4,
    parameter int GAP   = 4,
    parameter int DEPTH = 4
) (
    input  logic              c,
    input  logic              r,
    lvds_tx_framer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dr_q, dr_d;
    logic [NW-1:0]   nib_q, nib_d;
    logic            half_q, half_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [3:0]      held_q, held_d;
    logic [1:0]      o_q, o_d;
    logic            busy_q, busy_d;
    logic            uf_q, uf_d;
    logic            push, pop, uf_set;

    assign push = bus.dv && dr_q;

    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        half_d  = half_q;
        gap_d   = gap_q;
        held_d  = held_q;
        o_d     = 2'b11;
        busy_d  = 1'b0;
        pop     = 1'b0;
        uf_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) state_d = S_START;
            end
            S_START: begin
                o_d     = 2'b10;
                busy_d  = 1'b1;
                nib_d   = '0;
                half_d  = 1'b0;
                state_d = S_DATA;
            end
            S_DATA: begin
                busy_d = 1'b1;
                if (!half_q) begin
                    // An empty FIFO at slot start sends all-ones rather than stalling the frame.
                    if (cnt_q != '0) begin
                        pop    = 1'b1;
                        held_d = mem_q[rp_q];
                        o_d    = mem_q[rp_q][3:2];
                    end else begin
                        held_d = 4'hF;
                        uf_set = 1'b1;
                    end
                    half_d = 1'b1;
                end else begin
                    o_d    = held_q[1:0];
                    half_d = 1'b0;
                    if (nib_q == NW'(NNIB - 1)) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        nib_d = nib_q + NW'(1);
                    end
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
                else                       gap_d   = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        wp_d  = wp_q + AW'(push);
        rp_d  = rp_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        dr_d  = (cnt_d != CW'(DEPTH));
        uf_d  = uf_set | (uf_q & ~bus.uf_clr);
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            dr_q    <= 1'b1;
            nib_q   <= '0;
            half_q  <= 1'b0;
            gap_q   <= '0;
            held_q  <= 4'hF;
            o_q     <= 2'b11;
            busy_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            dr_q    <= dr_d;
            nib_q   <= nib_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            held_q  <= held_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            uf_q    <= uf_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge c) begin
        if (push) mem_q[wp_q] <= bus.d;
    end

    assign bus.dr        = dr_q;
    assign bus.o         = o_q;
    assign bus.busy      = busy_q;
    assign bus.underflow = uf_q;
endmodule

// File: tb/tb_lvds_tx_framer.sv
// Bench for lvds_tx_framer: accepted nibbles go to a scoreboard; a line monitor decodes frames.
module tb_lvds_tx_framer;
    localparam int NNIB = 4, GAP = 4, DEPTH = 4;

    logic c = 1'b0;
    logic r = 1'b1;
    lvds_tx_framer_if bus();

    lvds_tx_framer #(.NNIB(NNIB), .GAP(GAP), .DEPTH(DEPTH)) dut (.c(c), .r(r), .bus(bus));

    always #5 c = ~c;

    typedef struct { int e; logic [3:0] n; } ent_t;
    typedef enum { M_IDLE, M_DATA, M_GAP } mph_t;

    ent_t exp_q[$];
    int   starts[$];
    int   cyc = 0, n_chk = 0, n_fail = 0;
    logic ufclr_e = 1'b0;

    mph_t       ph = M_IDLE;
    bit         prev_idle = 1'b1, half = 1'b0, set_f, pend, st, uf_model = 1'b0;
    int         slot = 0, gcnt = 0;
    logic [3:0] expn = 4'h0;
    ent_t       tmp;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Acceptance: a nibble enters the FIFO at an edge where dv and dr were both high.
    always @(posedge c) begin
        cyc = cyc + 1;
        ufclr_e = bus.uf_clr;
        if (!r && bus.dv && bus.dr) exp_q.push_back('{e: cyc, n: bus.d});
    end

    // Line monitor: samples each clock's bits mid-cycle and decodes the frame structure.
    always @(negedge c) begin
        if (r) begin
            ph = M_IDLE; prev_idle = 1'b1; uf_model = 1'b0; half = 1'b0;
        end else begin
            set_f = 1'b0;
            case (ph)
                M_IDLE: begin
                    // A start bit follows one idle clock once a nibble has been queued long enough.
                    pend = (exp_q.size() > 0) && (exp_q[0].e <= cyc - 2);
                    st = prev_idle && pend;
                    chk("idle_or_start", bus.o, st ? 8'h2 : 8'h3);
                    chk("busy_idle", bus.busy, st);
                    if (st) begin
                        ph = M_DATA; slot = 0; half = 1'b0; starts.push_back(cyc);
                    end
                    prev_idle = 1'b1;
                end
                M_DATA: begin
                    chk("busy_data", bus.busy, 1);
                    if (!half) begin
                        if (exp_q.size() > 0 && exp_q[0].e < cyc) begin
                            tmp = exp_q.pop_front();
                            expn = tmp.n;
                        end else begin
                            expn = 4'hF; set_f = 1'b1;
                        end
                        chk("nibble_hi", bus.o, expn[3:2]);
                        half = 1'b1;
                    end else begin
                        chk("nibble_lo", bus.o, expn[1:0]);
                        half = 1'b0;
                        slot++;
                        if (slot == NNIB) begin ph = M_GAP; gcnt = 0; end
                    end
                end
                M_GAP: begin
                    chk("gap_line", bus.o, 8'h3);
                    chk("busy_gap", bus.busy, 1);
                    gcnt++;
                    if (gcnt == GAP) begin ph = M_IDLE; prev_idle = 1'b0; end
                end
                default: ph = M_IDLE;
            endcase
            uf_model = set_f ? 1'b1 : (ufclr_e ? 1'b0 : uf_model);
            chk("underflow", bus.underflow, uf_model);
            chk("dr", bus.dr, exp_q.size() != DEPTH);
        end
    end

    task automatic push(input logic [3:0] n, output int acc);
        int t = 0;
        bus.d = n; bus.dv = 1'b1;
        while (!bus.dr && t < 300) begin @(negedge c); t++; end
        if (t >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout: got dr=0 expected dr=1 within 300 cycles");
        end
        @(negedge c);
        acc = cyc;
        bus.dv = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() > 0 || ph != M_IDLE || !prev_idle) && t < 1000) begin
            @(negedge c); t++;
        end
        n_chk++;
        if (t >= 1000) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d queued expected 0", exp_q.size());
        end
        repeat (3) @(negedge c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, s0, t;
        logic [3:0] b2b [12];
        b2b = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h9, 4'h1, 4'hE, 4'h7, 4'h2, 4'hB, 4'h6, 4'hD};
        bus.d = 4'h0; bus.dv = 1'b0; bus.uf_clr = 1'b0;

        #12;
        chk("rst_o", bus.o, 8'h3);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dr", bus.dr, 1);
        chk("rst_uf", bus.underflow, 0);
        @(negedge c); #2 r = 1'b0;
        @(negedge c);

        // Single frame 1,2,3,4 from reset.
        for (int i = 1; i <= 4; i++) push(4'(i), acc);
        drain();
        chk("single_frames", 8'(starts.size()), 1);

        // Back-to-back frames with the FIFO kept non-empty.
        s0 = starts.size();
        for (int i = 0; i < 12; i++) push(b2b[i], acc);
        drain();
        chk("b2b_frames", 8'(starts.size() - s0), 3);
        for (int i = s0 + 1; i < starts.size(); i++) chk("b2b_period", 8'(starts[i] - starts[i-1]), 14);

        // Underflow, then clear it.
        push(4'h9, acc); push(4'h6, acc);
        drain();
        chk("uf_set", bus.underflow, 1);
        bus.uf_clr = 1'b1; @(negedge c); bus.uf_clr = 1'b0;
        chk("uf_cleared", bus.underflow, 0);

        // Underflow with clear held high: setting must win on the set clock.
        bus.uf_clr = 1'b1;
        push(4'h9, acc); push(4'h6, acc);
        drain();
        bus.uf_clr = 1'b0;
        @(negedge c);

        // Backpressure: fill the FIFO during the gap, then a held fifth nibble.
        push(4'h8, acc); push(4'h4, acc); push(4'h2, acc); push(4'h1, acc);
        t = 0;
        while (ph != M_GAP && t < 200) begin @(negedge c); t++; end
        chk("reach_gap", t < 200, 1);
        push(4'h3, acc); push(4'h6, acc); push(4'h9, acc); push(4'hC, acc);
        chk("dr_full", bus.dr, 0);
        push(4'h5, acc);
        chk("late_accept", 8'(acc - starts[$]), 2);
        drain();
        bus.uf_clr = 1'b1; @(negedge c); bus.uf_clr = 1'b0; @(negedge c);

        // Asynchronous reset in the middle of the second nibble.
        push(4'hB, acc); push(4'hC, acc); push(4'hD, acc); push(4'hE, acc);
        t = 0;
        while (!(ph == M_DATA && slot == 1) && t < 200) begin @(negedge c); t++; end
        chk("reach_slot2", t < 200, 1);
        #2 r = 1'b1;
        #1;
        chk("midrst_o", bus.o, 8'h3);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_dr", bus.dr, 1);
        exp_q.delete();
        repeat (2) @(negedge c);
        #2 r = 1'b0;
        @(negedge c);
        s0 = starts.size();
        for (int i = 0; i < 4; i++) push(4'h7, acc);
        drain();
        chk("post_rst_frames", 8'(starts.size() - s0), 1);
        chk("post_rst_uf", bus.underflow, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bus.dv = ($urandom_range(0, 3) == 0);
            bus.d = 4'($urandom);
            bus.uf_clr = ($urandom_range(0, 15) == 0);
            @(negedge c);
        end
        bus.dv = 1'b0; bus.uf_clr = 1'b0;
        drain();
        chk("final_empty", 8'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
